// File: rtl/pulse_stretch_queue.sv
// rtl/pulse_stretch_queue.sv - stretches single-cycle event pulses into fixed-length output windows, with a queue for events that arrive while a window is running
//
// Each accepted event produces one high window on level_out that lasts HOLD_CYCLES.
// A low gap of GAP_CYCLES always follows the window.
// Events that arrive during a window or a gap are counted in a pending counter.
// They are replayed in order, one window per event.
// When the counter is full, a new event is dropped and the sticky overflow flag is set.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   pulse_in   event input
//   level_out  stretched output level (registered)
//   busy       high while in HOLD or GAP (registered)
//   pending    queued events that have not started yet (registered)
//   overflow   sticky: an event was dropped because pending was saturated
//
// Optional feature (macro PULSE_STRETCH_EDGE_EN):
//   When defined, only a rising edge of pulse_in counts as an event.
//   A level held high for several cycles is therefore one event.
//   When undefined, every high cycle of pulse_in counts as an event.

module pulse_stretch_queue #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [PEND_W-1:0] pending_next;
  logic              overflow_next;
  logic              consume;
  logic              direct;
  logic              event_in;

`ifdef PULSE_STRETCH_EDGE_EN
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= pulse_in;
  end

  // The edge is decoded from the registered previous value.
  // Because of this, edge mode adds no latency.
  assign event_in = pulse_in & ~prev;
`else
  assign event_in = pulse_in;
`endif

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    pending_next  = pending;
    overflow_next = overflow;
    consume       = 1'b0;
    direct        = 1'b0;

    case (state)
      IDLE: begin
        if (event_in) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (pending != '0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
          consume    = 1'b1;
        end else if (event_in) begin
          // A pulse in the last gap cycle with an empty queue starts the
          // next window directly and never enters the queue.
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
          direct     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Queue bookkeeping only happens while a window or a gap is running.
    // In IDLE, an event starts a window immediately.
    // A new event and a consumption in the same cycle cancel each other.
    if (state != IDLE && !direct) begin
      if (event_in && !consume) begin
        if (pending == PEND_MAX) overflow_next = 1'b1;
        else                     pending_next  = pending + PEND_W'(1);
      end else if (!event_in && consume) begin
        pending_next = pending - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pending   <= pending_next;
      overflow  <= overflow_next;
      level_out <= (state_next == HOLD);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch_queue.sv
// tb/tb_pulse_stretch_queue.sv - directed self-checking bench for pulse_stretch_queue

module tb_pulse_stretch_queue;

  localparam int PEND_W = 3;
  localparam int NCYC   = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              pulse_in = 1'b0;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic              pmask   [NCYC];
  logic              rmask   [NCYC];
  logic              lev_rec [NCYC];
  logic              busy_rec[NCYC];
  logic              ovf_rec [NCYC];
  logic [PEND_W-1:0] pend_rec[NCYC];

  pulse_stretch_queue #(
    .HOLD_CYCLES(8),
    .GAP_CYCLES (4),
    .PEND_W     (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    pulse_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_masks();
    for (int i = 0; i < NCYC; i++) begin
      pmask[i] = 1'b0;
      rmask[i] = 1'b0;
    end
  endtask

  // Cycle c is the interval after the c-th edge that follows reset.
  // Inputs set in cycle c are sampled at the edge that ends cycle c.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      pulse_in = pmask[c];
      rst      = rmask[c];
      #4;
      lev_rec[c]  = level_out;
      busy_rec[c] = busy;
      ovf_rec[c]  = overflow;
      pend_rec[c] = pending;
      @(posedge clk); #1;
    end
    pulse_in = 1'b0;
    rst      = 1'b0;
  endtask

  function automatic int count_rises(input int from, input int n);
    int r = 0;
    for (int c = from; c < n; c++)
      if (lev_rec[c] && (c == 0 || !lev_rec[c-1])) r++;
    return r;
  endfunction

  function automatic int max_pending(input int n);
    int m = 0;
    for (int c = 0; c < n; c++)
      if (int'(pend_rec[c]) > m) m = int'(pend_rec[c]);
    return m;
  endfunction

  function automatic int invariant_breaks(input int n);
    int b = 0;
    for (int c = 0; c < n; c++)
      if (lev_rec[c] && !busy_rec[c]) b++;
    return b;
  endfunction

  task automatic test_reset();
    do_reset();
    #4;
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", level_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int hi;
    do_reset(); clear_masks();
    pmask[10] = 1'b1;
    run_cycles(40);
    hi = 0;
    for (int c = 0; c < 40; c++) if (lev_rec[c]) hi++;
    checks++; if (hi != 8) begin errors++; $display("FAIL single_high_len got %0d want 8", hi); end
    checks++; if (lev_rec[10] !== 1'b0 || lev_rec[11] !== 1'b1) begin errors++; $display("FAIL single_rise got c10=%b c11=%b want 0 1", lev_rec[10], lev_rec[11]); end
    checks++; if (lev_rec[18] !== 1'b1 || lev_rec[19] !== 1'b0) begin errors++; $display("FAIL single_fall got c18=%b c19=%b want 1 0", lev_rec[18], lev_rec[19]); end
    checks++; if (busy_rec[10] !== 1'b0 || busy_rec[11] !== 1'b1) begin errors++; $display("FAIL single_busy_start got c10=%b c11=%b want 0 1", busy_rec[10], busy_rec[11]); end
    checks++; if (busy_rec[22] !== 1'b1 || busy_rec[23] !== 1'b0) begin errors++; $display("FAIL single_busy_end got c22=%b c23=%b want 1 0", busy_rec[22], busy_rec[23]); end
    checks++; if (max_pending(40) != 0) begin errors++; $display("FAIL single_pending got %0d want 0", max_pending(40)); end
    checks++; if (invariant_breaks(40) != 0) begin errors++; $display("FAIL single_invariant got %0d want 0", invariant_breaks(40)); end
  endtask

  task automatic test_queued();
    do_reset(); clear_masks();
    pmask[10] = 1'b1; pmask[12] = 1'b1; pmask[14] = 1'b1;
    run_cycles(60);
    checks++; if (pend_rec[13] !== 3'd1) begin errors++; $display("FAIL queued_pend13 got %0d want 1", pend_rec[13]); end
    checks++; if (pend_rec[15] !== 3'd2) begin errors++; $display("FAIL queued_pend15 got %0d want 2", pend_rec[15]); end
    checks++; if (lev_rec[22] !== 1'b0 || lev_rec[23] !== 1'b1) begin errors++; $display("FAIL queued_rise23 got c22=%b c23=%b want 0 1", lev_rec[22], lev_rec[23]); end
    checks++; if (lev_rec[34] !== 1'b0 || lev_rec[35] !== 1'b1) begin errors++; $display("FAIL queued_rise35 got c34=%b c35=%b want 0 1", lev_rec[34], lev_rec[35]); end
    checks++; if (pend_rec[23] !== 3'd1) begin errors++; $display("FAIL queued_pend23 got %0d want 1", pend_rec[23]); end
    checks++; if (pend_rec[35] !== 3'd0) begin errors++; $display("FAIL queued_pend35 got %0d want 0", pend_rec[35]); end
    checks++; if (count_rises(0, 60) != 3) begin errors++; $display("FAIL queued_windows got %0d want 3", count_rises(0, 60)); end
    checks++; if (lev_rec[42] !== 1'b1 || lev_rec[43] !== 1'b0) begin errors++; $display("FAIL queued_last_fall got c42=%b c43=%b want 1 0", lev_rec[42], lev_rec[43]); end
  endtask

  task automatic test_last_gap();
    do_reset(); clear_masks();
    pmask[10] = 1'b1; pmask[22] = 1'b1;
    run_cycles(60);
    checks++; if (lev_rec[23] !== 1'b1 || busy_rec[23] !== 1'b1) begin errors++; $display("FAIL lastgap_rise23 got lvl=%b busy=%b want 1 1", lev_rec[23], busy_rec[23]); end
    checks++; if (max_pending(60) != 0) begin errors++; $display("FAIL lastgap_pending got %0d want 0", max_pending(60)); end
    checks++; if (count_rises(0, 60) != 2) begin errors++; $display("FAIL lastgap_windows got %0d want 2", count_rises(0, 60)); end
    checks++; if (busy_rec[35] !== 1'b0) begin errors++; $display("FAIL lastgap_idle35 got %b want 0", busy_rec[35]); end
  endtask

  task automatic test_saturation();
    do_reset(); clear_masks();
    for (int c = 10; c <= 18; c++) pmask[c] = 1'b1;
    run_cycles(NCYC);
    checks++; if (pend_rec[18] !== 3'd7) begin errors++; $display("FAIL sat_pend18 got %0d want 7", pend_rec[18]); end
    checks++; if (ovf_rec[18] !== 1'b0) begin errors++; $display("FAIL sat_ovf18 got %b want 0", ovf_rec[18]); end
    checks++; if (ovf_rec[19] !== 1'b1 || pend_rec[19] !== 3'd7) begin errors++; $display("FAIL sat_ovf19 got ovf=%b pend=%0d want 1 7", ovf_rec[19], pend_rec[19]); end
    checks++; if (ovf_rec[NCYC-1] !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got %b want 1", ovf_rec[NCYC-1]); end
    checks++; if (count_rises(0, NCYC) != 8) begin errors++; $display("FAIL sat_windows got %0d want 8", count_rises(0, NCYC)); end
    checks++; if (busy_rec[NCYC-1] !== 1'b0) begin errors++; $display("FAIL sat_final_idle got %b want 0", busy_rec[NCYC-1]); end
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_masks();
    for (int c = 10; c <= 13; c++) pmask[c] = 1'b1;
    rmask[15] = 1'b1;
    run_cycles(60);
    checks++; if (pend_rec[15] !== 3'd3 || lev_rec[15] !== 1'b1) begin errors++; $display("FAIL rstmid_pre got pend=%0d lvl=%b want 3 1", pend_rec[15], lev_rec[15]); end
    checks++; if (lev_rec[16] !== 1'b0 || busy_rec[16] !== 1'b0 || pend_rec[16] !== 3'd0 || ovf_rec[16] !== 1'b0)
      begin errors++; $display("FAIL rstmid_post got lvl=%b busy=%b pend=%0d ovf=%b want 0 0 0 0", lev_rec[16], busy_rec[16], pend_rec[16], ovf_rec[16]); end
    checks++; if (count_rises(16, 60) != 0) begin errors++; $display("FAIL rstmid_no_windows got %0d want 0", count_rises(16, 60)); end
  endtask

  task automatic test_level_hold();
    do_reset(); clear_masks();
    for (int c = 10; c <= 29; c++) pmask[c] = 1'b1;
    run_cycles(40);
`ifdef PULSE_STRETCH_EDGE_EN
    checks++; if (count_rises(0, 40) != 1) begin errors++; $display("FAIL hold_windows got %0d want 1", count_rises(0, 40)); end
    checks++; if (lev_rec[11] !== 1'b1 || lev_rec[18] !== 1'b1 || lev_rec[19] !== 1'b0) begin errors++; $display("FAIL hold_window_span got c11=%b c18=%b c19=%b want 1 1 0", lev_rec[11], lev_rec[18], lev_rec[19]); end
    checks++; if (max_pending(40) != 0 || ovf_rec[39] !== 1'b0) begin errors++; $display("FAIL hold_queue got pend=%0d ovf=%b want 0 0", max_pending(40), ovf_rec[39]); end
`else
    checks++; if (max_pending(40) != 7) begin errors++; $display("FAIL hold_pending got %0d want 7", max_pending(40)); end
    checks++; if (ovf_rec[39] !== 1'b1) begin errors++; $display("FAIL hold_overflow got %b want 1", ovf_rec[39]); end
    checks++; if (lev_rec[11] !== 1'b1 || lev_rec[23] !== 1'b1) begin errors++; $display("FAIL hold_windows got c11=%b c23=%b want 1 1", lev_rec[11], lev_rec[23]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_last_gap();
    test_saturation();
    test_reset_mid();
    test_level_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
